// File: rtl/de_mux_4_1_pkg.sv
// Shared types and constants for the 1-to-4 registered demux.
// Select encoding is fixed: 00..11 map to Out1..Out4.
package de_mux_4_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_OUT1 = 2'b00;
  localparam sel_t SEL_OUT2 = 2'b01;
  localparam sel_t SEL_OUT3 = 2'b10;
  localparam sel_t SEL_OUT4 = 2'b11;

  localparam int NOUT = 4;

endpackage

// File: rtl/de_mux_4_1_dec.sv
// Combinational 2-to-4 one-hot decoder.
// Shared by the output load gating and the out_sel flag.
module dec_2to4
  import de_mux_4_1_pkg::*;
(
  input  sel_t       sel,
  output logic [3:0] y
);

  // one-hot decode of the select code
  always_comb begin
    y = 4'b0000;
    unique case (sel)
      SEL_OUT1: y = 4'b0001;
      SEL_OUT2: y = 4'b0010;
      SEL_OUT3: y = 4'b0100;
      SEL_OUT4: y = 4'b1000;
      default:  y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/de_mux_4_1.sv
// Registered 1-to-4 demultiplexer with capture enable.
// HOLD picks clear-to-zero or hold for unselected outputs.
module de_mux_4_1
  import de_mux_4_1_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       S,
  input  logic             en,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [3:0]       out_sel
);

  logic [3:0]                  hot;
  logic [NOUT-1:0][WIDTH-1:0]  q;

  dec_2to4 u_dec (
    .sel (sel_t'(S)),
    .y   (hot)
  );

  for (genvar i = 0; i < NOUT; i++) begin : g_bank
    logic [WIDTH-1:0] r;

    // one flop bank per output: load, clear or hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= '0;
      end else if (en) begin
        if (hot[i]) begin
          r <= A;
        end else if (HOLD == 0) begin
          r <= '0;
        end
      end
    end

    assign q[i] = r;
  end

  // flag which output was written on the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sel <= 4'b0000;
    end else if (en) begin
      out_sel <= hot;
    end else begin
      out_sel <= 4'b0000;
    end
  end

  assign Out1 = q[0];
  assign Out2 = q[1];
  assign Out3 = q[2];
  assign Out4 = q[3];

endmodule

// File: tb/tb_de_mux_4_1.sv
// Directed bench for de_mux_4_1, HOLD=0 and HOLD=1 side by side.
// Inputs change on negedge, outputs sampled on the next negedge.
module tb_de_mux_4_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A;
  logic [1:0] S;
  logic       en;

  logic [7:0] c1, c2, c3, c4;
  logic [3:0] csel;
  logic [7:0] h1, h2, h3, h4;
  logic [3:0] hsel;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  de_mux_4_1 #(.WIDTH(8), .HOLD(0)) dut_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .S       (S),
    .en      (en),
    .Out1    (c1),
    .Out2    (c2),
    .Out3    (c3),
    .Out4    (c4),
    .out_sel (csel)
  );

  de_mux_4_1 #(.WIDTH(8), .HOLD(1)) dut_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .S       (S),
    .en      (en),
    .Out1    (h1),
    .Out2    (h2),
    .Out3    (h3),
    .Out4    (h4),
    .out_sel (hsel)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    A     = 8'h66;
    S     = 2'b11;
    #1;
    total_cnt++;
    if ({c1, c2, c3, c4, csel} !== 36'h0) begin
      $display("FAIL reset_async_clr got=%h req=0",
               {c1, c2, c3, c4, csel});
    end else pass_cnt++;
    total_cnt++;
    if ({h1, h2, h3, h4, hsel} !== 36'h0) begin
      $display("FAIL reset_async_hold got=%h req=0",
               {h1, h2, h3, h4, hsel});
    end else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      S = ~S;
      @(negedge clk);
      total_cnt++;
      if ({c1, c2, c3, c4, csel, hsel} !== 40'h0) begin
        $display("FAIL reset_held_%0d got=%h req=0", k,
                 {c1, c2, c3, c4, csel, hsel});
      end else pass_cnt++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hold();
    A = 8'h11;
    S = 2'b00;
    @(negedge clk);
    total_cnt++;
    if ({h1, h2, h3, h4, hsel} !== {32'h11000000, 4'b0001}) begin
      $display("FAIL hold_first got=%h req=%h",
               {h1, h2, h3, h4, hsel}, {32'h11000000, 4'b0001});
    end else pass_cnt++;
    A = 8'h22;
    S = 2'b01;
    @(negedge clk);
    total_cnt++;
    if ({h1, h2, h3, h4, hsel} !== {32'h11220000, 4'b0010}) begin
      $display("FAIL hold_keep got=%h req=%h",
               {h1, h2, h3, h4, hsel}, {32'h11220000, 4'b0010});
    end else pass_cnt++;
    total_cnt++;
    if ({c1, c2, c3, c4, csel} !== {32'h00220000, 4'b0010}) begin
      $display("FAIL hold_clr_side got=%h req=%h",
               {c1, c2, c3, c4, csel}, {32'h00220000, 4'b0010});
    end else pass_cnt++;
  endtask

  task automatic test_mapping();
    logic [1:0]  sv [4];
    logic [35:0] ev [4];
    sv[0] = 2'b00; ev[0] = {32'h66000000, 4'b0001};
    sv[1] = 2'b11; ev[1] = {32'h00000066, 4'b1000};
    sv[2] = 2'b01; ev[2] = {32'h00660000, 4'b0010};
    sv[3] = 2'b10; ev[3] = {32'h00006600, 4'b0100};
    A = 8'h66;
    for (int k = 0; k < 4; k++) begin
      S = sv[k];
      @(negedge clk);
      total_cnt++;
      if ({c1, c2, c3, c4, csel} !== ev[k]) begin
        $display("FAIL map_s%0d got=%h req=%h", sv[k],
                 {c1, c2, c3, c4, csel}, ev[k]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    A  = 8'hFF;
    S  = 2'b00;
    @(negedge clk);
    total_cnt++;
    if ({c1, c2, c3, c4, csel} !== {32'h00006600, 4'b0000}) begin
      $display("FAIL en_low_clr got=%h req=%h",
               {c1, c2, c3, c4, csel}, {32'h00006600, 4'b0000});
    end else pass_cnt++;
    total_cnt++;
    if ({h1, h2, h3, h4, hsel} !== {32'h66666666, 4'b0000}) begin
      $display("FAIL en_low_hold got=%h req=%h",
               {h1, h2, h3, h4, hsel}, {32'h66666666, 4'b0000});
    end else pass_cnt++;
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    A = 8'h66;
    S = 2'b01;
    @(negedge clk);
    total_cnt++;
    if (c2 !== 8'h66) begin
      $display("FAIL mid_pre got=%h req=66", c2);
    end else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({c1, c2, c3, c4, csel, hsel} !== 40'h0) begin
      $display("FAIL mid_async got=%h req=0",
               {c1, c2, c3, c4, csel, hsel});
    end else pass_cnt++;
    #1 rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({c1, c2, c3, c4, csel} !== {32'h00660000, 4'b0010}) begin
      $display("FAIL mid_recap got=%h req=%h",
               {c1, c2, c3, c4, csel}, {32'h00660000, 4'b0010});
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    A = 8'hA5;
    S = 2'b11;
    @(negedge clk);
    total_cnt++;
    if ({c4, csel} !== {8'hA5, 4'b1000}) begin
      $display("FAIL b2b_first got=%h req=%h",
               {c4, csel}, {8'hA5, 4'b1000});
    end else pass_cnt++;
    A = 8'h5A;
    S = 2'b00;
    #1;
    total_cnt++;
    if ({c1, c4, csel} !== {8'h00, 8'hA5, 4'b1000}) begin
      $display("FAIL no_comb_path got=%h req=%h",
               {c1, c4, csel}, {8'h00, 8'hA5, 4'b1000});
    end else pass_cnt++;
    S = 2'b11;
    @(negedge clk);
    total_cnt++;
    if ({c4, csel} !== {8'h5A, 4'b1000}) begin
      $display("FAIL b2b_second got=%h req=%h",
               {c4, csel}, {8'h5A, 4'b1000});
    end else pass_cnt++;
    A = 8'h00;
    S = 2'b10;
    @(negedge clk);
    total_cnt++;
    if ({c1, c2, c3, c4, csel} !== {32'h0, 4'b0100}) begin
      $display("FAIL zero_data got=%h req=%h",
               {c1, c2, c3, c4, csel}, {32'h0, 4'b0100});
    end else pass_cnt++;
    total_cnt++;
    if ({h3, h4, hsel} !== {8'h00, 8'h5A, 4'b0100}) begin
      $display("FAIL zero_hold got=%h req=%h",
               {h3, h4, hsel}, {8'h00, 8'h5A, 4'b0100});
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_mapping();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/de_mux_4_1.md
DE_MUX_4_1 -- requirements
Module: de_mux_4_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the data width of A and Out1..Out4.
REQ-002 The block SHALL have parameter HOLD, default 0; 0 means unselected outputs clear to zero each enabled cycle, 1 means unselected outputs hold their value.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port A, input, WIDTH bits, the data to route.
REQ-006 The block SHALL have port S, input, 2 bits, the output select.
REQ-007 The block SHALL have port en, input, 1 bit, the capture enable; the bench ties it high for plain demux use.
REQ-008 The block SHALL have ports Out1, Out2, Out3 and Out4, each an output of WIDTH bits, the registered routed data.
REQ-009 The block SHALL have port out_sel, output, 4 bits, a one-hot flag of the output written last cycle; bit0 = Out1 through bit3 = Out4.

Function
REQ-010 Select mapping SHALL be: S=00 -> Out1, S=01 -> Out2, S=10 -> Out3, S=11 -> Out4.
REQ-011 On a rising clk edge with en=1, the selected output SHALL load A.
REQ-012 With HOLD=0, the three unselected outputs SHALL load zero on that same edge.
REQ-013 With HOLD=1, the three unselected outputs SHALL keep their previous values.
REQ-014 Latency SHALL be exactly one clk cycle from A/S sampled to the outputs updated; there is no combinational path from A or S to any output.
REQ-015 On a rising clk edge with en=1, out_sel SHALL load the one-hot decode of S.
REQ-016 On a rising clk edge with en=0, out_sel SHALL load 0000 and Out1..Out4 SHALL hold regardless of HOLD.
REQ-017 When S changes every cycle, each cycle's A SHALL go only to the output selected in that same cycle, with no cross-cycle mixing.
REQ-018 When A = 0 is routed, the selected output SHALL become 0 and out_sel SHALL still flag it.
REQ-019 An X/Z value on S SHALL NOT be required to be handled; the bench drives only legal values.

Reset
REQ-020 While rst_n=0, Out1..Out4 and out_sel SHALL be 0, asserted asynchronously without waiting for clk.
REQ-021 Reset asserted mid-operation SHALL clear all outputs immediately, overriding any capture.
REQ-022 The first capture SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-023 A shared package de_mux_4_1_pkg SHALL hold the select typedef (2-bit) and constants SEL_OUT1=00, SEL_OUT2=01, SEL_OUT3=10, SEL_OUT4=11.
REQ-024 One sub-module, dec_2to4, SHALL provide a combinational 2-to-4 one-hot decode used for both output-load gating and out_sel.
REQ-025 Output registers SHALL be one flop bank per output plus a 4-bit out_sel register.

Verification
REQ-026 Reset case: rst_n=0 with A=0x66 and S=11 toggling -> all outputs 0 and out_sel=0000, asynchronously.
REQ-027 Mapping case: en=1, A=0x66, S=00 then 11 then 01 then 10, one cycle each -> after each edge Out1, Out4, Out2, Out3 respectively =0x66, others 0 (HOLD=0), out_sel=0001, 1000, 0010, 0100.
REQ-028 HOLD=1 case: A=0x11 with S=00, then A=0x22 with S=01 -> Out1=0x11 persists while Out2=0x22; Out3=Out4=0.
REQ-029 Enable case: after Out3=0x66, en=0 with A=0xFF and S=00 -> outputs unchanged and out_sel=0000.
REQ-030 Reset mid-stream case: rst_n pulsed low between clk edges while Out2=0x66 -> Out2 drops to 0 before the next edge.
REQ-031 Back-to-back case: A=0xA5 with S=11, then A=0x5A with S=11 -> Out4=0xA5 then 0x5A on consecutive edges.
